fifo_flag_ctrl: RTL and testbench
=================================

// Module: fifo_flag_ctrl
// PURPOSE
//  Controller for the FIFO overflow/underflow sticky-flag monitor.
//  - Samples the wr_overflow/rd_underflow flags and counts each event in saturating counters.
//  - Issues timed wr_clear/rd_clear pulses so the monitor re-arms.
//  - Sits between the FIFO flag monitor and the host status registers.
//  - Flags are already synchronised into clk before this block.
// PARAMETERS
//  CNT_W   16  width of each event counter
//  CLR_W   2   clear pulse width in clk cycles (>=1)
//  HOLDOFF 4   cycles after a clear pulse during which flags are ignored (>=1)
// PORTS
//  clk          in  1      single clock for all logic
//  reset        in  1      asynchronous, active-high reset
//  enable       in  1      1 = monitor/count/auto-clear active
//  auto_clear   in  1      1 = clear a flag automatically after counting it
//  host_clear   in  1      1-cycle pulse: zero counters/seen bits, clear both flags
//  wr_overflow  in  1      sticky overflow flag from monitor
//  rd_underflow in  1      sticky underflow flag from monitor
//  wr_clear     out 1      clear to monitor write side (registered)
//  rd_clear     out 1      clear to monitor read side (registered)
//  ovf_count    out CNT_W  overflow events counted (saturating)
//  unf_count    out CNT_W  underflow events counted (saturating)
//  ovf_seen     out 1      sticky: at least one overflow since last host_clear
//  unf_seen     out 1      sticky: at least one underflow since last host_clear
//  busy         out 1      1 while in CLEAR or HOLD
// BEHAVIOUR
//  Reset values
//  - State = IDLE.
//  - All outputs = 0.
//  - armed_ovf = armed_unf = 1.
//  - Clear mask = 00.
//  States
//  - IDLE:  monitor the flags.
//  - CLEAR: drive the selected clear outputs.
//  - HOLD:  wait out HOLDOFF, ignoring flags.
//  IDLE (enable=1), at each rising edge:
//  - ev_o = wr_overflow & armed_ovf; ev_u = rd_underflow & armed_unf.
//  - If ev_o: ovf_count++ (holds at 2^CNT_W-1), ovf_seen <= 1, armed_ovf <= 0.
//  - ev_u handled the same way with unf_count, unf_seen and armed_unf.
//  - ev_o and ev_u may both be counted on the same edge.
//  - If auto_clear=1 and (ev_o|ev_u):
//    - mask <= {ev_u,ev_o}; go to CLEAR.
//    - On that same edge, wr_clear <= ev_o and rd_clear <= ev_u.
//  - If auto_clear=0: stay in IDLE. The flag is not cleared and the armed bit stays 0 until host_clear.
//  - Each event is therefore counted once per flag assertion. Latency is 1 cycle, flag to count.
//  CLEAR:
//  - Hold the masked clear outputs high for exactly CLR_W cycles.
//  - Then drive both clears to 0 and go to HOLD.
//  HOLD:
//  - Count HOLDOFF cycles; flags are ignored (not counted).
//  - On exit to IDLE: armed bits in mask <= 1; mask <= 00.
//  enable=0:
//  - In IDLE: no counting, no transitions.
//  - A CLEAR/HOLD sequence already in progress always completes.
//  host_clear (any state, any enable):
//  - Counters and seen bits <= 0; mask <= 11; go to CLEAR with both clears high (restarts CLR_W).
//  - host_clear has priority: a flag event on the same edge is not counted.
//  - Both armed bits <= 1 when the following HOLD ends.
//  - host_clear arriving during CLEAR/HOLD restarts the sequence.
//  Counters never wrap.
// TESTING
//  1. CLR_W=2, HOLDOFF=4, auto=1:
//     - Stimulus: wr_overflow high in cycle 10, falls once wr_clear has been seen.
//     - Required: ovf_count=1 at cycle 11; wr_clear high cycles 11-12; busy low at cycle 17.
//  2. auto=0, wr_overflow held high 50 cycles:
//     - Required: ovf_count=1, wr_clear never asserted.
//     - Then host_clear: count=0, wr_clear and rd_clear both pulse 2 cycles.
//  3. Both flags high on the same edge, auto=1:
//     - Required: both counts=1; wr_clear and rd_clear high together for 2 cycles.
//  4. CNT_W=4, auto=1, 20 overflow events, each after the previous re-arm:
//     - Required: ovf_count saturates at 15.
//  5. Mid-sequence events:
//     - host_clear during HOLD: sequence restarts, counts 0.
//     - Flag asserted during HOLD: not counted.
//     - Async reset asserted in CLEAR: all outputs 0 immediately.

Source files
------------

// File: rtl/fifo_flag_ctrl.sv
// Controller for the FIFO overflow/underflow sticky-flag monitor: counts flag events,
// issues timed clear pulses to re-arm the monitor, then holds off before watching again.
module fifo_flag_ctrl #(
  parameter int CNT_W   = 16,
  parameter int CLR_W   = 2,
  parameter int HOLDOFF = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             auto_clear,
  input  logic             host_clear,
  input  logic             wr_overflow,
  input  logic             rd_underflow,
  output logic             wr_clear,
  output logic             rd_clear,
  output logic [CNT_W-1:0] ovf_count,
  output logic [CNT_W-1:0] unf_count,
  output logic             ovf_seen,
  output logic             unf_seen,
  output logic             busy
);

  localparam int CLR_CW = (CLR_W > 1) ? $clog2(CLR_W) : 1;
  localparam int HLD_CW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CLR_CW-1:0] CLR_LAST = CLR_CW'(CLR_W - 1);
  localparam logic [HLD_CW-1:0] HLD_LAST = HLD_CW'(HOLDOFF - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, HOLD} state_t;

  state_t            state, state_next;
  logic [CLR_CW-1:0] clr_cnt, clr_cnt_next;
  logic [HLD_CW-1:0] hold_cnt, hold_cnt_next;
  logic [1:0]        mask, mask_next;
  logic              armed_ovf, armed_ovf_next;
  logic              armed_unf, armed_unf_next;
  logic              wr_clear_next, rd_clear_next;
  logic [CNT_W-1:0]  ovf_count_next, unf_count_next;
  logic              ovf_seen_next, unf_seen_next;
  logic              ev_o, ev_u;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      clr_cnt   <= '0;
      hold_cnt  <= '0;
      mask      <= 2'b00;
      armed_ovf <= 1'b1;
      armed_unf <= 1'b1;
      wr_clear  <= 1'b0;
      rd_clear  <= 1'b0;
      ovf_count <= '0;
      unf_count <= '0;
      ovf_seen  <= 1'b0;
      unf_seen  <= 1'b0;
    end else begin
      state     <= state_next;
      clr_cnt   <= clr_cnt_next;
      hold_cnt  <= hold_cnt_next;
      mask      <= mask_next;
      armed_ovf <= armed_ovf_next;
      armed_unf <= armed_unf_next;
      wr_clear  <= wr_clear_next;
      rd_clear  <= rd_clear_next;
      ovf_count <= ovf_count_next;
      unf_count <= unf_count_next;
      ovf_seen  <= ovf_seen_next;
      unf_seen  <= unf_seen_next;
    end
  end

  // host_clear overrides everything, including an event arriving on the same edge.
  always_comb begin
    state_next     = state;
    clr_cnt_next   = clr_cnt;
    hold_cnt_next  = hold_cnt;
    mask_next      = mask;
    armed_ovf_next = armed_ovf;
    armed_unf_next = armed_unf;
    wr_clear_next  = wr_clear;
    rd_clear_next  = rd_clear;
    ovf_count_next = ovf_count;
    unf_count_next = unf_count;
    ovf_seen_next  = ovf_seen;
    unf_seen_next  = unf_seen;
    ev_o           = wr_overflow & armed_ovf;
    ev_u           = rd_underflow & armed_unf;

    if (host_clear) begin
      ovf_count_next = '0;
      unf_count_next = '0;
      ovf_seen_next  = 1'b0;
      unf_seen_next  = 1'b0;
      mask_next      = 2'b11;
      wr_clear_next  = 1'b1;
      rd_clear_next  = 1'b1;
      clr_cnt_next   = '0;
      state_next     = CLEAR;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            if (ev_o) begin
              if (ovf_count != CNT_MAX) ovf_count_next = ovf_count + 1'b1;
              ovf_seen_next  = 1'b1;
              armed_ovf_next = 1'b0;
            end
            if (ev_u) begin
              if (unf_count != CNT_MAX) unf_count_next = unf_count + 1'b1;
              unf_seen_next  = 1'b1;
              armed_unf_next = 1'b0;
            end
            if (auto_clear && (ev_o || ev_u)) begin
              mask_next     = {ev_u, ev_o};
              wr_clear_next = ev_o;
              rd_clear_next = ev_u;
              clr_cnt_next  = '0;
              state_next    = CLEAR;
            end
          end
        end
        CLEAR: begin
          if (clr_cnt == CLR_LAST) begin
            wr_clear_next = 1'b0;
            rd_clear_next = 1'b0;
            hold_cnt_next = '0;
            state_next    = HOLD;
          end else begin
            clr_cnt_next = clr_cnt + 1'b1;
          end
        end
        HOLD: begin
          // Only the sides that were cleared get re-armed.
          if (hold_cnt == HLD_LAST) begin
            if (mask[0]) armed_ovf_next = 1'b1;
            if (mask[1]) armed_unf_next = 1'b1;
            mask_next  = 2'b00;
            state_next = IDLE;
          end else begin
            hold_cnt_next = hold_cnt + 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_fifo_flag_ctrl.sv
// Bench for fifo_flag_ctrl: directed stimulus pushes cycle-tagged expectations into a
// scoreboard queue; a negedge monitor pops and compares them against the DUT outputs.
module tb_fifo_flag_ctrl;

  localparam int CNT_W = 4;
  localparam int F_OVF = 0, F_UNF = 1, F_WR = 2, F_RD = 3, F_BUSY = 4, F_OSEEN = 5, F_USEEN = 6;

  logic             clk = 1'b0;
  logic             reset, enable, auto_clear, host_clear, wr_overflow, rd_underflow;
  logic             wr_clear, rd_clear, ovf_seen, unf_seen, busy;
  logic [CNT_W-1:0] ovf_count, unf_count;

  int    cyc = 0;
  int    tests_run = 0;
  int    failed = 0;
  int    exp_cyc[$];
  int    exp_field[$];
  int    exp_value[$];
  string exp_name[$];

  fifo_flag_ctrl #(.CNT_W(CNT_W), .CLR_W(2), .HOLDOFF(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .auto_clear(auto_clear),
    .host_clear(host_clear), .wr_overflow(wr_overflow), .rd_underflow(rd_underflow),
    .wr_clear(wr_clear), .rd_clear(rd_clear), .ovf_count(ovf_count), .unf_count(unf_count),
    .ovf_seen(ovf_seen), .unf_seen(unf_seen), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int field_value(int f);
    case (f)
      F_OVF:   return int'(ovf_count);
      F_UNF:   return int'(unf_count);
      F_WR:    return int'(wr_clear);
      F_RD:    return int'(rd_clear);
      F_BUSY:  return int'(busy);
      F_OSEEN: return int'(ovf_seen);
      default: return int'(unf_seen);
    endcase
  endfunction

  task automatic expect_at(input int c, input int f, input int v, input string n);
    exp_cyc.push_back(c);
    exp_field.push_back(f);
    exp_value.push_back(v);
    exp_name.push_back(n);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compares every expectation due in the current cycle.
  always @(negedge clk) begin
    while (exp_cyc.size() > 0 && exp_cyc[0] <= cyc) begin
      int c, f, v, act;
      string n;
      c = exp_cyc.pop_front();
      f = exp_field.pop_front();
      v = exp_value.pop_front();
      n = exp_name.pop_front();
      act = field_value(f);
      tests_run++;
      if (c != cyc) begin
        failed++;
        $display("[TB] FAIL %s: due at cycle %0d, checked late at %0d (got %0d, want %0d)", n, c, cyc, act, v);
      end else if (act != v) begin
        failed++;
        $display("[TB] FAIL %s @cycle %0d: got %0d, want %0d", n, cyc, act, v);
      end
    end
  end

  initial begin
    int s, h;
    reset = 1'b1; enable = 1'b1; auto_clear = 1'b1; host_clear = 1'b0;
    wr_overflow = 1'b0; rd_underflow = 1'b0;

    // Reset values
    step(3);
    s = cyc;
    expect_at(s, F_OVF, 0, "reset_ovf");
    expect_at(s, F_WR, 0, "reset_wr");
    expect_at(s, F_RD, 0, "reset_rd");
    expect_at(s, F_BUSY, 0, "reset_busy");
    expect_at(s, F_OSEEN, 0, "reset_oseen");
    reset = 1'b0;
    step(3);

    // Single overflow with auto clear
    s = cyc;
    expect_at(s+1, F_OVF, 1, "t1_count");
    expect_at(s+1, F_WR, 1, "t1_wr_on1");
    expect_at(s+1, F_BUSY, 1, "t1_busy");
    expect_at(s+2, F_WR, 1, "t1_wr_on2");
    expect_at(s+3, F_WR, 0, "t1_wr_off");
    expect_at(s+3, F_RD, 0, "t1_rd_off");
    expect_at(s+6, F_BUSY, 1, "t1_busy_hold");
    expect_at(s+7, F_BUSY, 0, "t1_busy_done");
    wr_overflow = 1'b1;
    step(1);
    wr_overflow = 1'b0;
    step(8);

    // auto_clear off, flag held high 50 cycles: counted once, never cleared
    s = cyc;
    expect_at(s+1, F_OVF, 2, "t2_count");
    expect_at(s+1, F_WR, 0, "t2_no_wr");
    expect_at(s+1, F_BUSY, 0, "t2_idle");
    expect_at(s+1, F_OSEEN, 1, "t2_seen");
    expect_at(s+25, F_WR, 0, "t2_no_wr_mid");
    expect_at(s+50, F_OVF, 2, "t2_count_end");
    expect_at(s+50, F_WR, 0, "t2_no_wr_end");
    auto_clear = 1'b0;
    wr_overflow = 1'b1;
    step(50);
    h = cyc;
    expect_at(h+1, F_OVF, 0, "hc_count");
    expect_at(h+1, F_OSEEN, 0, "hc_seen");
    expect_at(h+1, F_WR, 1, "hc_wr1");
    expect_at(h+1, F_RD, 1, "hc_rd1");
    expect_at(h+2, F_WR, 1, "hc_wr2");
    expect_at(h+2, F_RD, 1, "hc_rd2");
    expect_at(h+3, F_WR, 0, "hc_wr_off");
    expect_at(h+3, F_RD, 0, "hc_rd_off");
    expect_at(h+7, F_BUSY, 0, "hc_done");
    wr_overflow = 1'b0;
    host_clear = 1'b1;
    step(1);
    host_clear = 1'b0;
    auto_clear = 1'b1;
    step(8);

    // Both flags on the same edge
    s = cyc;
    expect_at(s+1, F_OVF, 1, "t3_ovf");
    expect_at(s+1, F_UNF, 1, "t3_unf");
    expect_at(s+1, F_WR, 1, "t3_wr1");
    expect_at(s+1, F_RD, 1, "t3_rd1");
    expect_at(s+1, F_USEEN, 1, "t3_useen");
    expect_at(s+2, F_WR, 1, "t3_wr2");
    expect_at(s+2, F_RD, 1, "t3_rd2");
    expect_at(s+3, F_WR, 0, "t3_wr_off");
    expect_at(s+3, F_RD, 0, "t3_rd_off");
    wr_overflow = 1'b1;
    rd_underflow = 1'b1;
    step(1);
    wr_overflow = 1'b0;
    rd_underflow = 1'b0;
    step(8);

    // enable low in IDLE: flag ignored
    s = cyc;
    expect_at(s+1, F_OVF, 1, "en_no_count");
    expect_at(s+1, F_BUSY, 0, "en_idle");
    expect_at(s+3, F_OVF, 1, "en_no_count3");
    expect_at(s+3, F_WR, 0, "en_no_wr");
    enable = 1'b0;
    wr_overflow = 1'b1;
    step(3);
    wr_overflow = 1'b0;
    enable = 1'b1;
    step(2);

    // Saturation: 20 overflow events on a 4-bit counter
    host_clear = 1'b1;
    step(1);
    host_clear = 1'b0;
    step(8);
    for (int k = 1; k <= 20; k++) begin
      s = cyc;
      expect_at(s+1, F_OVF, (k > 15) ? 15 : k, $sformatf("sat_%0d", k));
      wr_overflow = 1'b1;
      step(1);
      wr_overflow = 1'b0;
      step(8);
    end

    // host_clear during HOLD restarts the sequence
    s = cyc;
    expect_at(s+1, F_UNF, 1, "t5a_unf");
    expect_at(s+1, F_RD, 1, "t5a_rd");
    expect_at(s+5, F_OVF, 0, "t5a_ovf_zero");
    expect_at(s+5, F_UNF, 0, "t5a_unf_zero");
    expect_at(s+5, F_WR, 1, "t5a_wr_restart");
    expect_at(s+5, F_RD, 1, "t5a_rd_restart");
    expect_at(s+7, F_RD, 0, "t5a_rd_off");
    expect_at(s+10, F_BUSY, 1, "t5a_busy_hold");
    expect_at(s+11, F_BUSY, 0, "t5a_done");
    rd_underflow = 1'b1;
    step(1);
    rd_underflow = 1'b0;
    step(3);
    host_clear = 1'b1;
    step(1);
    host_clear = 1'b0;
    step(8);

    // Flag during HOLD is not counted
    s = cyc;
    expect_at(s+1, F_OVF, 1, "t5b_ovf");
    expect_at(s+7, F_BUSY, 0, "t5b_done");
    expect_at(s+7, F_UNF, 0, "t5b_unf_ignored");
    expect_at(s+8, F_UNF, 0, "t5b_unf_after");
    expect_at(s+8, F_RD, 0, "t5b_no_rd");
    wr_overflow = 1'b1;
    step(1);
    wr_overflow = 1'b0;
    step(2);
    rd_underflow = 1'b1;
    step(2);
    rd_underflow = 1'b0;
    step(5);

    // Async reset while in CLEAR
    wr_overflow = 1'b1;
    step(1);
    s = cyc;
    wr_overflow = 1'b0;
    #2;
    reset = 1'b1;
    expect_at(s, F_WR, 0, "t5c_wr");
    expect_at(s, F_OVF, 0, "t5c_ovf");
    expect_at(s, F_BUSY, 0, "t5c_busy");
    expect_at(s, F_OSEEN, 0, "t5c_seen");
    step(2);
    reset = 1'b0;
    step(10);

    if (exp_cyc.size() != 0) begin
      tests_run++;
      failed++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, want 0", exp_cyc.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
